result_fifo_writer: RTL and testbench
=====================================

Name: result_fifo_writer

Overview:
PL-side writer for the result buffer that the PS drains. It is the reverse direction of the sample FIFO path. Classifier results are pushed one per cycle into a true-dual-port BRAM, with port A written by PL and port B read by PS over the BRAM controller. The PS loads an expected element count; after the last element commits, the block raises a level done flag and a one-cycle interrupt pulse.

Parameters:
WIDTH, 16, bits per result word.
DEPTH_BIT, 13, address bits; capacity is 2^DEPTH_BIT words.

Ports:
clk  in  1  single clock for the PL side.
rst  in  1  reset; synchronous, active-high.
i_push  in  1  push request.
i_data  in  WIDTH  result word to push.
o_full  out  1  threshold element has been accepted; no further pushes are accepted.
o_overflow  out  1  sticky flag: a push was rejected.
o_count  out  DEPTH_BIT+1  number of pushes accepted.
i_ptr_rst  in  1  run restart: clears pointer and flags.
i_thsh_val  in  DEPTH_BIT  number of elements minus 1.
i_thsh_vld  in  1  loads i_thsh_val and arms the writer.
o_done  out  1  level: all elements are committed to BRAM.
o_irq  out  1  one-cycle pulse on entry to DONE.
bram_en_ps  in  1  PS port enable.
bram_dout_ps  out  32  PS read data; bits [31:WIDTH] are 0.
bram_din_ps  in  32  unused; the PS port is read-only.
bram_we_ps  in  4  ignored; the port B write enable is tied 0.
bram_addr_ps  in  DEPTH_BIT+2  byte address; word index is [DEPTH_BIT+1:2].
bram_clk_ps  in  1  PS clock.
bram_rst_ps  in  1  PS port reset.

Behaviour:
- Reset values: rst high gives state IDLE, wptr 0 and thsh 0. All outputs reset to 0: o_full, o_overflow, o_count, o_done, o_irq, wr_vld.
- State machine:
  - IDLE -> ARMED on i_thsh_vld; the threshold register is loaded from i_thsh_val.
  - ARMED -> FLUSH on accepting the push with wptr == thsh.
  - FLUSH -> DONE unconditionally on the next cycle.
  - DONE holds until i_ptr_rst.
- Accept rule: accept = i_push & (state == ARMED) & !i_ptr_rst.
- Accepted push:
  - wr_vld <= 1, wr_addr <= wptr, wr_data <= i_data.
  - wptr <= wptr + 1; o_count follows wptr.
- BRAM port A: wea = wr_vld & !i_ptr_rst, addra = wr_addr, dina = wr_data. The write commits one edge after the stage register loads.
- Latency: for a push accepted at edge t, data is readable on port B from t+1. For the last element accepted at edge t: o_full = 1 from t, FLUSH at t, DONE at t+1. In cycle numbering, the last push in cycle c gives o_done = 1 in cycle c+2 and o_irq high in cycle c+2 only.
- o_full: set on acceptance of the threshold element, cleared only by i_ptr_rst or rst.
- Overflow: i_push & !accept & !i_ptr_rst sets o_overflow, which is sticky. The rejected data is never written. This covers pushes in IDLE, FLUSH and DONE.
- Wrap: thsh ≤ 2^DEPTH_BIT − 1, so the full condition always precedes pointer wrap. o_count reaches 2^DEPTH_BIT without aliasing because it is DEPTH_BIT+1 bits.
- i_thsh_vld outside IDLE is ignored; the threshold is not reloaded.
- i_ptr_rst has priority over everything, in any state:
  - state IDLE; wptr, o_count, flags, o_done and o_irq cleared next cycle.
  - a concurrent push is dropped without flagging overflow.
  - a write in flight is squashed via the wea gate.
  - a concurrent i_thsh_vld is ignored.
- rst mid-run behaves like i_ptr_rst and also clears thsh. BRAM contents are not cleared.
- Port B is read-only: web = 0, doutb has 1-cycle read latency, and it is independent of PL state.

Decomposition:
- Shared package rf_fifo_pkg holds:
  - typedef enum logic [1:0] wr_state_t {IDLE, ARMED, FLUSH, DONE};
  - localparam PS_WORD_BYTES = 4, reusable by sample_fifo_paper.
- One sub-module: result_bram, a true-dual-port BRAM IP, WIDTH x 2^DEPTH_BIT, 1-cycle read latency on port B.
- wptr uses the existing counter_with_lat, with clear driven by i_ptr_rst | rst.

Test Plan:
1. Arm thsh=3; push 0xA0..0xA3 in consecutive cycles c..c+3 -> o_full=1 from c+4, o_done=1 and o_irq=1 in cycle c+5 only, o_count=4. PS reads byte addresses 0,4,8,12 and gets 0xA0..0xA3 with upper 16 bits 0.
2. After test 1, push 0xFF -> o_overflow=1; PS read at byte 16 still holds its prior contents; o_count stays 4.
3. Push 0x11 in IDLE before arming -> o_overflow=1, o_count=0, no port A write.
4. Arm thsh=5; push 2 words, then assert i_ptr_rst together with a push of 0x33 -> next cycle state IDLE, o_count=0, o_overflow=0, and the squashed address holds its old value.
5. Arm thsh=0; single push of 0x5A in cycle c -> o_full in c+1, o_done and o_irq in c+2, PS address 0 reads 0x5A.
6. Assert rst in FLUSH -> all outputs 0 next cycle, state IDLE, and a subsequent i_thsh_vld re-arms normally.

Source files
------------

// File: rtl/rf_fifo_pkg.sv
// rf_fifo_pkg: shared types and constants for the PL/PS FIFO buffers
package rf_fifo_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, FLUSH, DONE} wr_state_t;
  localparam int PS_WORD_BYTES = 4;
endpackage

// File: rtl/result_fifo_writer_if.sv
// result_fifo_writer_if: PL-side push and control bundle of the result FIFO writer
interface result_fifo_writer_if #(parameter int WIDTH = 16, parameter int DEPTH_BIT = 13);
  logic                 i_push;
  logic [WIDTH-1:0]     i_data;
  logic                 o_full;
  logic                 o_overflow;
  logic [DEPTH_BIT:0]   o_count;
  logic                 i_ptr_rst;
  logic [DEPTH_BIT-1:0] i_thsh_val;
  logic                 i_thsh_vld;
  logic                 o_done;
  logic                 o_irq;
  modport master (output i_push, i_data, i_ptr_rst, i_thsh_val, i_thsh_vld,
                  input o_full, o_overflow, o_count, o_done, o_irq);
  modport slave (input i_push, i_data, i_ptr_rst, i_thsh_val, i_thsh_vld,
                 output o_full, o_overflow, o_count, o_done, o_irq);
endinterface

// File: rtl/counter_with_lat.sv
// counter_with_lat: up counter with synchronous clear and count enable
module counter_with_lat #(parameter int W = 14) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) q <= clr ? '0 : en ? q + 1'b1 : q;
endmodule

// File: rtl/result_fifo_writer_bram.sv
// result_bram: true-dual-port BRAM, port A write-only, port B read-only with 1-cycle latency
module result_bram #(parameter int WIDTH = 16, parameter int DEPTH_BIT = 13) (
  input  logic                 clka,
  input  logic                 wea,
  input  logic [DEPTH_BIT-1:0] addra,
  input  logic [WIDTH-1:0]     dina,
  input  logic                 clkb,
  input  logic                 rstb,
  input  logic                 enb,
  input  logic [DEPTH_BIT-1:0] addrb,
  output logic [WIDTH-1:0]     doutb
);
  logic [WIDTH-1:0] mem [2**DEPTH_BIT];
  always_ff @(posedge clka) if (wea) mem[addra] <= dina;
  always_ff @(posedge clkb) begin
    if (rstb) doutb <= '0;
    else if (enb) doutb <= mem[addrb];
  end
endmodule

// File: rtl/result_fifo_writer.sv
// result_fifo_writer: PL writer filling a PS-drained result BRAM up to a loaded element count
module result_fifo_writer import rf_fifo_pkg::*; #(parameter int WIDTH = 16, parameter int DEPTH_BIT = 13) (
  input  logic                 clk,
  input  logic                 rst,
  result_fifo_writer_if.slave  pl,
  input  logic                 bram_en_ps,
  output logic [31:0]          bram_dout_ps,
  input  logic [31:0]          bram_din_ps,
  input  logic [3:0]           bram_we_ps,
  input  logic [DEPTH_BIT+1:0] bram_addr_ps,
  input  logic                 bram_clk_ps,
  input  logic                 bram_rst_ps
);
  localparam int AL = $clog2(PS_WORD_BYTES);
  wr_state_t state, state_n;
  logic [DEPTH_BIT-1:0] thsh, wr_addr;
  logic [DEPTH_BIT:0] wptr;
  logic [WIDTH-1:0] wr_data, doutb;
  logic accept, last, wr_vld, full, ovf, irq;
  logic unused_ps;
  assign accept = pl.i_push & (state == ARMED) & !pl.i_ptr_rst;
  assign last = accept & (wptr == {1'b0, thsh});
  always_comb state_n = pl.i_ptr_rst ? IDLE :
                        state == IDLE ? (pl.i_thsh_vld ? ARMED : IDLE) :
                        state == ARMED ? (last ? FLUSH : ARMED) : DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      thsh   <= '0;
      wr_vld <= 1'b0;
      full   <= 1'b0;
      ovf    <= 1'b0;
      irq    <= 1'b0;
    end else begin
      state  <= state_n;
      thsh   <= (state == IDLE && pl.i_thsh_vld && !pl.i_ptr_rst) ? pl.i_thsh_val : thsh;
      wr_vld <= accept;
      full   <= !pl.i_ptr_rst & (full | last);
      ovf    <= !pl.i_ptr_rst & (ovf | (pl.i_push & !accept));
      irq    <= !pl.i_ptr_rst & (state == FLUSH);
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_addr <= wptr[DEPTH_BIT-1:0];
      wr_data <= pl.i_data;
    end
  end
  counter_with_lat #(.W(DEPTH_BIT+1)) u_wptr (
    .clk (clk),
    .clr (pl.i_ptr_rst | rst),
    .en  (accept),
    .q   (wptr)
  );
  // a stage write still in flight when the run restarts is squashed here
  result_bram #(.WIDTH(WIDTH), .DEPTH_BIT(DEPTH_BIT)) u_bram (
    .clka  (clk),
    .wea   (wr_vld & !pl.i_ptr_rst),
    .addra (wr_addr),
    .dina  (wr_data),
    .clkb  (bram_clk_ps),
    .rstb  (bram_rst_ps),
    .enb   (bram_en_ps),
    .addrb (bram_addr_ps[DEPTH_BIT+1:AL]),
    .doutb (doutb)
  );
  assign pl.o_full     = full;
  assign pl.o_overflow = ovf;
  assign pl.o_count    = wptr;
  assign pl.o_done     = state == DONE;
  assign pl.o_irq      = irq;
  assign bram_dout_ps  = {{(32-WIDTH){1'b0}}, doutb};
  assign unused_ps     = ^{bram_din_ps, bram_we_ps, bram_addr_ps[AL-1:0]};
endmodule

// File: tb/tb_result_fifo_writer.sv
// tb_result_fifo_writer: randomized and directed checks against a count-based reference model
module tb_result_fifo_writer;
  localparam int W = 16, DB = 13;
  logic clk = 1'b0, rst;
  logic bram_en_ps, bram_rst_ps;
  logic [31:0] bram_dout_ps, bram_din_ps;
  logic [3:0] bram_we_ps;
  logic [DB+1:0] bram_addr_ps;
  int passed = 0, total = 0;
  bit armed, ovf, pend;
  int n, acc, age, pa;
  logic [W-1:0] pd;
  logic [W-1:0] mem [32];
  always #5 clk = ~clk;
  result_fifo_writer_if #(.WIDTH(W), .DEPTH_BIT(DB)) pl ();
  result_fifo_writer #(.WIDTH(W), .DEPTH_BIT(DB)) dut (
    .clk          (clk),
    .rst          (rst),
    .pl           (pl),
    .bram_en_ps   (bram_en_ps),
    .bram_dout_ps (bram_dout_ps),
    .bram_din_ps  (bram_din_ps),
    .bram_we_ps   (bram_we_ps),
    .bram_addr_ps (bram_addr_ps),
    .bram_clk_ps  (clk),
    .bram_rst_ps  (bram_rst_ps)
  );
  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  // model: a run accepts n = thsh+1 pushes, done two cycles after the last one
  task model();
    bit a;
    a = pl.i_push && armed && acc < n && !pl.i_ptr_rst;
    if (pend && !pl.i_ptr_rst) mem[pa[4:0]] = pd;
    if (rst) begin
      armed = 0; acc = 0; ovf = 0; age = -1; pend = 0; n = 0;
    end else if (pl.i_ptr_rst) begin
      armed = 0; acc = 0; ovf = 0; age = -1; pend = 0;
    end else begin
      if (age >= 0) age++;
      if (pl.i_push && !a) ovf = 1;
      pend = a;
      if (a) begin
        pa = acc; pd = pl.i_data; acc++;
        if (acc == n) age = 0;
      end
      if (!armed && pl.i_thsh_vld) begin
        armed = 1; n = int'(pl.i_thsh_val) + 1;
      end
    end
  endtask
  task tick();
    @(posedge clk);
    model();
    #1;
    check("count", 32'(pl.o_count), 32'(acc));
    check("full", 32'(pl.o_full), 32'(armed && acc == n));
    check("overflow", 32'(pl.o_overflow), 32'(ovf));
    check("done", 32'(pl.o_done), 32'(age >= 1));
    check("irq", 32'(pl.o_irq), 32'(age == 1));
  endtask
  task drive(input bit push, input logic [W-1:0] d, input bit pr, input bit tv, input logic [DB-1:0] tval);
    pl.i_push = push; pl.i_data = d; pl.i_ptr_rst = pr; pl.i_thsh_vld = tv; pl.i_thsh_val = tval;
    tick();
  endtask
  task idle(input int k);
    repeat (k) drive(0, '0, 0, 0, '0);
  endtask
  task psread(input int a);
    bram_en_ps = 1; bram_addr_ps = (DB+2)'(a * 4);
    idle(1);
    check("ps_rd", bram_dout_ps, {16'h0, mem[a]});
    bram_en_ps = 0;
  endtask
  task run(input int th, input logic [W-1:0] base);
    drive(0, '0, 0, 1, DB'(th));
    for (int i = 0; i <= th; i++) drive(1, base + W'(i), 0, 0, '0);
  endtask
  initial begin
    armed = 0; ovf = 0; pend = 0; n = 0; acc = 0; age = -1; pa = 0; pd = '0;
    bram_en_ps = 0; bram_rst_ps = 0; bram_din_ps = 32'hDEAD_BEEF; bram_we_ps = 4'hF; bram_addr_ps = '0;
    rst = 1;
    idle(2);
    rst = 0;
    drive(0, '0, 0, 1, DB'(31));
    for (int i = 0; i < 32; i++) drive(1, 16'($urandom), 0, 0, '0);
    idle(3);
    drive(0, '0, 1, 0, '0);
    run(3, 16'hA0);
    idle(3);
    for (int i = 0; i < 4; i++) psread(i);
    drive(1, 16'hFF, 0, 0, '0);
    idle(2);
    psread(4);
    drive(0, '0, 1, 0, '0);
    drive(1, 16'h11, 0, 0, '0);
    idle(2);
    psread(0);
    drive(0, '0, 1, 0, '0);
    drive(0, '0, 0, 1, DB'(5));
    drive(1, 16'h21, 0, 0, '0);
    drive(1, 16'h22, 0, 0, '0);
    drive(1, 16'h33, 1, 0, '0);
    idle(2);
    for (int i = 0; i < 3; i++) psread(i);
    run(0, 16'h5A);
    idle(3);
    psread(0);
    drive(0, '0, 1, 0, '0);
    run(2, 16'h70);
    rst = 1;
    idle(1);
    rst = 0;
    run(2, 16'h80);
    idle(3);
    for (int i = 0; i < 3; i++) psread(i);
    drive(0, '0, 1, 0, '0);
    for (int s = 0; s < 8; s++) begin
      drive(0, '0, 0, 1, 13'($urandom_range(0, 20)));
      for (int k = 0; k < 200 && !(armed && acc == n); k++)
        drive($urandom % 3 != 0, 16'($urandom), $urandom % 40 == 0, $urandom % 8 == 0, 13'($urandom_range(0, 20)));
      idle(3);
      drive(1, 16'($urandom), 0, $urandom % 2 == 0, 13'($urandom_range(0, 20)));
      idle(1);
      drive(0, '0, 1, 0, '0);
    end
    idle(2);
    for (int i = 0; i < 32; i++) psread(i);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
